// File: rtl/mcdp_pkg.sv
// Shared definitions for the multicycle datapath: ALU operation codes,
// next-PC and ALU-B source selects, and the memory sequencer states.
package mcdp_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_XOR = 4'd3,
      ALU_NOR = 4'd4,
      ALU_SUB = 4'd6,
      ALU_SLT = 4'd7,
      ALU_SLL = 4'd8,
      ALU_SRL = 4'd9,
      ALU_SRA = 4'd10,
      ALU_LUI = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'd0,
      PC_ALUOUT = 2'd1,
      PC_JUMP   = 2'd2,
      PC_REGA   = 2'd3
   } pcsrc_e;

   typedef enum logic [1:0] {
      SRCB_B     = 2'd0,
      SRCB_FOUR  = 2'd1,
      SRCB_IMM   = 2'd2,
      SRCB_IMMSH = 2'd3
   } srcb_e;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_BUSY = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mcdp_alu.sv
// Combinational ALU for the multicycle datapath. Shifts operate on the B
// operand by the instruction shamt; LUI shifts the B operand (the immediate)
// up by 16. Carry and overflow are only meaningful for ADD and SUB.
module mcdp_alu
   import mcdp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      shamt_i,
   input  logic [3:0]      ctrl_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            sign_o,
   output logic            ov_o,
   output logic            cout_o
);

   logic [XLEN:0]          sum;
   logic [XLEN:0]          dif;
   logic signed [XLEN-1:0] sra_res;
   logic                   slt_res;

   // SUB is A + ~B + 1 so the carry out is the no-borrow indication.
   assign sum     = {1'b0, a_i} + {1'b0, b_i};
   assign dif     = {1'b0, a_i} + {1'b0, ~b_i} + {{XLEN{1'b0}}, 1'b1};
   assign sra_res = $signed(b_i) >>> shamt_i;
   assign slt_res = $signed(a_i) < $signed(b_i);

   // Result mux and flag generation.
   always_comb begin
      result_o = '0;
      ov_o     = 1'b0;
      cout_o   = 1'b0;
      case (ctrl_i)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_ADD: begin
            result_o = sum[XLEN-1:0];
            cout_o   = sum[XLEN];
            ov_o     = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_NOR: result_o = ~(a_i | b_i);
         ALU_SUB: begin
            result_o = dif[XLEN-1:0];
            cout_o   = dif[XLEN];
            ov_o     = (a_i[XLEN-1] != b_i[XLEN-1]) && (dif[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt_res};
         ALU_SLL: result_o = b_i << shamt_i;
         ALU_SRL: result_o = b_i >> shamt_i;
         ALU_SRA: result_o = sra_res;
         ALU_LUI: result_o = b_i << 16;
         default: result_o = '0;
      endcase
      zero_o = (result_o == '0);
      sign_o = result_o[XLEN-1];
   end

endmodule

// File: rtl/mc_datapath_p.sv
// Multicycle MIPS-style datapath: PC, IR/MDR/A/B/ALUOut holding registers,
// register file, ALU and a registered memory request/ready sequencer.
// Optional feature macro: MCDP_FLAGS_REG_EN (registered ALU flags loaded by
// flagwrite); when undefined the flags are combinational and flagwrite is
// ignored.
module mc_datapath_p
   import mcdp_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pcwrite,
   input  logic            pcwritecond,
   input  logic            branchne,
   input  logic [1:0]      pcsrc,
   input  logic            iord,
   input  logic            memread,
   input  logic            memwrite,
   input  logic            irwrite,
   input  logic            regwrite,
   input  logic            regdst,
   input  logic            memtoreg,
   input  logic            signext,
   input  logic            alusrca,
   input  logic [1:0]      alusrcb,
   input  logic [3:0]      aluctrl,
   input  logic            flagwrite,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            mem_done,
   output logic            busy,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            zero,
   output logic            sign,
   output logic            ov,
   output logic            cout
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0] pc_q, mdr_q, a_q, b_q, aluout_q;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] rf_q [NREG];

   logic [AW-1:0]   rs, rt, rd, waddr;
   logic [XLEN-1:0] wdata, rd_a, rd_b, imm, srca, srcb, pc_next, jtarget;
   logic [XLEN-1:0] alu_res;
   logic            alu_zero, alu_sign, alu_ov, alu_cout, pc_load;

   mem_state_e      state_q, state_d;
   logic            mem_req_q, mem_we_q, ir_tgt_q, start, capture, rd_load;
   logic [XLEN-1:0] mem_addr_q, mem_wdata_q;

   // Register file addressing and read ports; r0 always reads as zero.
   assign rs    = ir_q[21 +: AW];
   assign rt    = ir_q[16 +: AW];
   assign rd    = ir_q[11 +: AW];
   assign waddr = regdst ? rd : rt;
   assign wdata = memtoreg ? mdr_q : aluout_q;
   assign rd_a  = (rs == '0) ? '0 : rf_q[rs];
   assign rd_b  = (rt == '0) ? '0 : rf_q[rt];

   // Register file write port, no reset; writes to r0 are dropped.
   always_ff @(posedge clk) begin
      if (regwrite && (waddr != '0)) rf_q[waddr] <= wdata;
   end

   assign imm     = signext ? {{(XLEN-16){ir_q[15]}}, ir_q[15:0]}
                            : {{(XLEN-16){1'b0}}, ir_q[15:0]};
   assign jtarget = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
   assign srca    = alusrca ? a_q : pc_q;

   // ALU B-operand and next-PC source selection.
   always_comb begin
      srcb    = b_q;
      pc_next = alu_res;
      case (alusrcb)
         SRCB_B:     srcb = b_q;
         SRCB_FOUR:  srcb = XLEN'(32'd4);
         SRCB_IMM:   srcb = imm;
         SRCB_IMMSH: srcb = imm << 2;
         default:    srcb = b_q;
      endcase
      case (pcsrc)
         PC_ALU:    pc_next = alu_res;
         PC_ALUOUT: pc_next = aluout_q;
         PC_JUMP:   pc_next = jtarget;
         PC_REGA:   pc_next = a_q;
         default:   pc_next = alu_res;
      endcase
   end

   mcdp_alu #(.XLEN(XLEN)) u_alu (
      .a_i      (srca),
      .b_i      (srcb),
      .shamt_i  (ir_q[10:6]),
      .ctrl_i   (aluctrl),
      .result_o (alu_res),
      .zero_o   (alu_zero),
      .sign_o   (alu_sign),
      .ov_o     (alu_ov),
      .cout_o   (alu_cout)
   );

   // Branches always use the live ALU zero, even with registered flags.
   assign pc_load = pcwrite | (pcwritecond & (alu_zero ^ branchne));

   // Memory sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= MS_IDLE;
      else       state_q <= state_d;
   end

   // Memory sequencer next state, completion and busy indication.
   always_comb begin
      state_d  = state_q;
      mem_done = 1'b0;
      busy     = 1'b0;
      start    = memread | memwrite;
      capture  = 1'b0;
      case (state_q)
         MS_IDLE: begin
            if (start) begin
               state_d = MS_BUSY;
               busy    = 1'b1;
               capture = 1'b1;
            end
         end
         MS_BUSY: begin
            if (mem_ready) begin
               mem_done = 1'b1;
               state_d  = MS_IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         default: state_d = MS_IDLE;
      endcase
   end

   assign rd_load = mem_done & ~mem_we_q;

   // Request qualifiers captured at the start strobe and held while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         ir_tgt_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_req_q <= (state_d == MS_BUSY);
         if (capture) begin
            mem_addr_q  <= iord ? aluout_q : pc_q;
            mem_wdata_q <= b_q;
            mem_we_q    <= memwrite;
            ir_tgt_q    <= irwrite;
         end
      end
   end

   // PC and holding registers; A, B and ALUOut reload every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         mdr_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
      end else begin
         if (pc_load) pc_q <= pc_next;
         if (rd_load) begin
            if (ir_tgt_q) ir_q  <= mem_rdata[31:0];
            else          mdr_q <= mem_rdata;
         end
         a_q      <= rd_a;
         b_q      <= rd_b;
         aluout_q <= alu_res;
      end
   end

`ifdef MCDP_FLAGS_REG_EN
   logic [3:0] flags_q;

   // Flag register, loaded only on flagwrite.
   always_ff @(posedge clk) begin
      if (reset)          flags_q <= 4'b0000;
      else if (flagwrite) flags_q <= {alu_zero, alu_sign, alu_ov, alu_cout};
   end

   assign {zero, sign, ov, cout} = flags_q;
`else
   logic unused_flagwrite;
   assign unused_flagwrite       = flagwrite;
   assign {zero, sign, ov, cout} = {alu_zero, alu_sign, alu_ov, alu_cout};
`endif

   assign pc        = pc_q;
   assign instr     = ir_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
